// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: decodes loads/stores, runs one data-memory transfer at a time, registers the result.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating them.
module mem_access_stage (
    input  logic        i_clk,
    input  logic        i_s_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr_ExMem,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rt_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr_MemAc,
    output logic [31:0] o_Mem_out_MemAc,
    output logic        o_misalign
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_WAIT_OUT = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] low);
        case (op)
            OP_LW, OP_SW:         return (low != 2'b00);
            OP_LH, OP_LHU, OP_SH: return low[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Low address bits forced to the natural alignment of the access size.
    function automatic logic [1:0] align_low(input logic [5:0] op, input logic [1:0] low);
        case (op)
            OP_LW, OP_SW:         return 2'b00;
            OP_LH, OP_LHU, OP_SH: return {low[1], 1'b0};
            default:              return low;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [5:0] op, input logic [1:0] low);
        case (op)
            OP_SB:   return 4'b0001 << low;
            OP_SH:   return low[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
        case (op)
            OP_SB:   return {4{rt[7:0]}};
            OP_SH:   return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] low,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rdata >> {low, 3'b000};
        half    = low[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  return {24'h000000, shifted[7:0]};
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0000, half};
            default: return rdata;
        endcase
    endfunction

    state_t      state_r;
    logic        valid_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_data_r;
    logic        misalign_r;
    logic        req_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] acc_instr_r;
    logic [31:0] acc_addr_r;
    logic [1:0]  acc_low_r;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_data_r;

    logic [5:0]  op_s;
    logic [5:0]  acc_op_s;
    logic [1:0]  low_s;
    logic        out_free_s;
    logic        accept_s;
    logic        is_mem_s;
    logic        trap_s;
    logic [31:0] acc_result_s;

    assign op_s       = i_instr_ExMem[31:26];
    assign acc_op_s   = acc_instr_r[31:26];
    assign low_s      = align_low(op_s, i_alu_out[1:0]);
    assign out_free_s = !valid_r || i_ready;
    assign o_ready    = (state_r == ST_IDLE) && out_free_s;
    assign accept_s   = i_valid && o_ready;
    assign is_mem_s   = is_load(op_s) || is_store(op_s);
    assign trap_s     = TRAP_EN && is_misaligned(op_s, i_alu_out[1:0]);

    // Result of the access completing this cycle: extracted load data, or the store's address.
    always_comb begin
        acc_result_s = acc_addr_r;
        if (is_load(acc_op_s)) begin
            acc_result_s = load_extract(acc_op_s, acc_low_r, i_dmem_rdata);
        end else begin
            acc_result_s = acc_addr_r;
        end
    end

    // Stage FSM, data-memory request registers and output register.
    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            state_r      <= ST_IDLE;
            valid_r      <= 1'b0;
            out_instr_r  <= 32'h0000_0000;
            out_data_r   <= 32'h0000_0000;
            misalign_r   <= 1'b0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            be_r         <= 4'b0000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            acc_instr_r  <= 32'h0000_0000;
            acc_addr_r   <= 32'h0000_0000;
            acc_low_r    <= 2'b00;
            hold_instr_r <= 32'h0000_0000;
            hold_data_r  <= 32'h0000_0000;
        end else begin
            misalign_r <= 1'b0;
            // Drain; any load of the output register below takes priority.
            if (valid_r && i_ready) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !is_mem_s) begin
                        out_instr_r <= i_instr_ExMem;
                        out_data_r  <= i_alu_out;
                        valid_r     <= 1'b1;
                    end else if (accept_s && trap_s) begin
                        out_instr_r <= 32'h0000_0000;
                        out_data_r  <= 32'h0000_0000;
                        valid_r     <= 1'b1;
                        misalign_r  <= 1'b1;
                    end else if (accept_s) begin
                        acc_instr_r <= i_instr_ExMem;
                        acc_addr_r  <= i_alu_out;
                        acc_low_r   <= low_s;
                        req_r       <= 1'b1;
                        we_r        <= is_store(op_s);
                        be_r        <= byte_enables(op_s, low_s);
                        addr_r      <= {i_alu_out[31:2], 2'b00};
                        wdata_r     <= store_data(op_s, i_rt_data);
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (i_dmem_ack) begin
                        req_r <= 1'b0;
                        we_r  <= 1'b0;
                        if (out_free_s) begin
                            out_instr_r <= acc_instr_r;
                            out_data_r  <= acc_result_s;
                            valid_r     <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            hold_instr_r <= acc_instr_r;
                            hold_data_r  <= acc_result_s;
                            state_r      <= ST_WAIT_OUT;
                        end
                    end
                end
                ST_WAIT_OUT: begin
                    if (out_free_s) begin
                        out_instr_r <= hold_instr_r;
                        out_data_r  <= hold_data_r;
                        valid_r     <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid         = valid_r;
    assign o_instr_MemAc   = out_instr_r;
    assign o_Mem_out_MemAc = out_data_r;
    assign o_misalign      = misalign_r;
    assign o_dmem_req      = req_r;
    assign o_dmem_we       = we_r;
    assign o_dmem_be       = be_r;
    assign o_dmem_addr     = addr_r;
    assign o_dmem_wdata    = wdata_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized traffic against a transaction-level model.
// Expectations follow MEM_ACCESS_MISALIGN_TRAP_EN when the bench is built with it.
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_s_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr_ExMem = 32'h0;
    logic [31:0] i_alu_out = 32'h0;
    logic [31:0] i_rt_data = 32'h0;
    logic        o_dmem_req, o_dmem_we;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instr_MemAc, o_Mem_out_MemAc;
    logic        o_misalign;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mem_access_stage dut (
        .i_clk(i_clk), .i_s_rst_n(i_s_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr_ExMem(i_instr_ExMem), .i_alu_out(i_alu_out), .i_rt_data(i_rt_data),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_be(o_dmem_be),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instr_MemAc(o_instr_MemAc), .o_Mem_out_MemAc(o_Mem_out_MemAc), .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model state
    bit          known = 1'b0;
    bit          vis_valid = 1'b0, hold_valid = 1'b0, busy = 1'b0, trap_pulse = 1'b0;
    logic [31:0] vis_instr, vis_data, hold_instr, hold_data;
    logic [31:0] b_instr, b_alu, b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        b_we;
    logic [1:0]  b_low;

    function automatic bit is_ld(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic bit misaligned(input logic [5:0] op, input logic [31:0] a);
        if (op == 6'h23 || op == 6'h2B) return (a % 4) != 0;
        if (op inside {6'h21, 6'h25, 6'h29}) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [1:0] low,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * low)) & 32'h0000_00FF;
        h = (rd >> (8 * low)) & 32'h0000_FFFF;
        case (op)
            6'h20:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            6'h21:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            6'h24:   return b;
            6'h25:   return h;
            default: return rd;
        endcase
    endfunction

    // One clock cycle: drive inputs, predict, let the edge happen, then compare.
    task automatic step(input logic rst_v, input logic valid_v, input logic [31:0] instr_v,
                        input logic [31:0] alu_v, input logic [31:0] rt_v, input logic ready_v,
                        input logic ack_v, input logic [31:0] rdata_v);
        logic [5:0]  op;
        logic [31:0] res;
        bit          exp_ready, free;
        i_s_rst_n = rst_v; i_valid = valid_v; i_instr_ExMem = instr_v; i_alu_out = alu_v;
        i_rt_data = rt_v; i_ready = ready_v; i_dmem_ack = ack_v; i_dmem_rdata = rdata_v;
        #1;
        op = instr_v[31:26];
        if (!rst_v) begin
            vis_valid = 1'b0; hold_valid = 1'b0; busy = 1'b0; trap_pulse = 1'b0; known = 1'b1;
        end else begin
            exp_ready = !busy && !hold_valid && (!vis_valid || ready_v);
            if (known) check_eq("o_ready", {31'd0, o_ready}, {31'd0, exp_ready});
            trap_pulse = 1'b0;
            free = !vis_valid || ready_v;
            if (vis_valid && ready_v) vis_valid = 1'b0;
            if (valid_v && exp_ready) begin
                if (!is_ld(op) && !is_st(op)) begin
                    vis_valid = 1'b1; vis_instr = instr_v; vis_data = alu_v;
                end else if (TRAP && misaligned(op, alu_v)) begin
                    vis_valid = 1'b1; vis_instr = 32'h0; vis_data = 32'h0; trap_pulse = 1'b1;
                end else begin
                    busy = 1'b1; b_instr = instr_v; b_alu = alu_v;
                    b_addr = alu_v & 32'hFFFF_FFFC;
                    b_we = is_st(op);
                    b_low = alu_v[1:0];
                    if (op == 6'h23 || op == 6'h2B) b_low = 2'b00;
                    if (op inside {6'h21, 6'h25, 6'h29}) b_low = alu_v[1:0] & 2'b10;
                    b_be = 4'hF;
                    if (op == 6'h29) b_be = alu_v[1] ? 4'hC : 4'h3;
                    if (op == 6'h28) b_be = 4'(1 << alu_v[1:0]);
                    b_wdata = rt_v;
                    if (op == 6'h28) b_wdata = (rt_v & 32'hFF) * 32'h0101_0101;
                    if (op == 6'h29) b_wdata = (rt_v & 32'hFFFF) * 32'h0001_0001;
                end
            end else if (busy && ack_v) begin
                res = is_ld(b_instr[31:26]) ? exp_load(b_instr[31:26], b_low, rdata_v) : b_alu;
                busy = 1'b0;
                if (free) begin
                    vis_valid = 1'b1; vis_instr = b_instr; vis_data = res;
                end else begin
                    hold_valid = 1'b1; hold_instr = b_instr; hold_data = res;
                end
            end else if (hold_valid && free) begin
                vis_valid = 1'b1; vis_instr = hold_instr; vis_data = hold_data; hold_valid = 1'b0;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_eq("o_valid", {31'd0, o_valid}, {31'd0, vis_valid});
        if (vis_valid) begin
            check_eq("out_instr", o_instr_MemAc, vis_instr);
            check_eq("out_data", o_Mem_out_MemAc, vis_data);
        end
        check_eq("dmem_req", {31'd0, o_dmem_req}, {31'd0, busy});
        if (busy) begin
            check_eq("dmem_addr", o_dmem_addr, b_addr);
            check_eq("dmem_we", {31'd0, o_dmem_we}, {31'd0, b_we});
            check_eq("dmem_be", {28'd0, o_dmem_be}, {28'd0, b_be});
            check_eq("dmem_wdata", o_dmem_wdata, b_wdata);
        end
        check_eq("misalign", {31'd0, o_misalign}, {31'd0, trap_pulse});
        if (!rst_v) begin
            check_eq("rst_instr", o_instr_MemAc, 32'h0);
            check_eq("rst_data", o_Mem_out_MemAc, 32'h0);
            check_eq("rst_addr", o_dmem_addr, 32'h0);
            check_eq("rst_wdata", o_dmem_wdata, 32'h0);
            check_eq("rst_be_we", {27'd0, o_dmem_be, o_dmem_we}, 32'h0);
        end
    endtask

    logic [5:0] ops [10] = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0F};

    initial begin
        logic [5:0]  op;
        logic [31:0] instr;
        @(negedge i_clk);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);

        // ADD passes alu result with latency 1
        step(1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("add_out", o_Mem_out_MemAc, 32'h0000_1234);

        // LB at 0x103, ack after three request cycles
        step(1'b1, 1'b1, {6'h20, 26'h0}, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("lb_addr", o_dmem_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80FF_FFFF);
        check_eq("lb_out", o_Mem_out_MemAc, 32'hFFFF_FF80);

        // SH at 0x202
        step(1'b1, 1'b1, {6'h29, 26'h0}, 32'h0000_0202, 32'hABCD_1234, 1'b1, 1'b0, 32'h0);
        check_eq("sh_be", {28'd0, o_dmem_be}, 32'h0000_000C);
        check_eq("sh_wdata", o_dmem_wdata, 32'h1234_1234);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h5555_5555);
        check_eq("sh_out", o_Mem_out_MemAc, 32'h0000_0202);

        // LW completing with downstream stalled, then released
        step(1'b1, 1'b1, {6'h23, 26'h0}, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 32'h0, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("lw_held", o_Mem_out_MemAc, 32'hCAFE_F00D);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset in ACCESS abandons the access; a late ack is ignored
        step(1'b1, 1'b1, {6'h23, 26'h0}, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1111_1111);
        check_eq("late_ack_valid", {31'd0, o_valid}, 32'h0);

        // LW at 0x301
        step(1'b1, 1'b1, {6'h23, 26'h0}, 32'h0000_0301, 32'h0, 1'b1, 1'b0, 32'h0);
        if (TRAP) begin
            check_eq("trap_pulse", {31'd0, o_misalign}, 32'h1);
            check_eq("trap_instr", o_instr_MemAc, 32'h0);
        end else begin
            check_eq("trunc_addr", o_dmem_addr, 32'h0000_0300);
        end
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            op = ops[$urandom_range(0, 9)];
            instr = {op, 26'($urandom)};
            step(($urandom % 400) != 0, ($urandom % 10) < 7, instr, $urandom, $urandom,
                 ($urandom % 10) < 6, busy ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                 $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
